// File: rtl/div5_serial_ctrl.sv
// div5_serial_ctrl: nibble-serial mod-15 accumulator deciding whether a BIT_WIDTH operand is divisible by 5.
// Latency: result valid NIBBLES cycles after acceptance (with DIV5_EARLY_EXIT_EN: 1 + index of highest nonzero nibble).
// Backpressure: result held stable in DONE until out_ready; no operand is accepted until the result is taken.
module div5_serial_ctrl #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_residue,
  output logic                 out_divisible,
  output logic                 busy
);

  localparam int NIBBLES = BIT_WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

  if ((BIT_WIDTH < 4) || ((BIT_WIDTH % 4) != 0)) begin : g_bad_width
    $error("div5_serial_ctrl: BIT_WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [BIT_WIDTH-1:0] shreg_q, shreg_d;
  logic [3:0]           acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [4:0]           sum;
  logic [BIT_WIDTH-1:0] shifted;
  logic                 last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum     = {1'b0, acc_q} + {1'b0, shreg_q[3:0]};
    shifted = shreg_q >> 4;
`ifdef DIV5_EARLY_EXIT_EN
    last    = (cnt_q == CNT_LAST) || (shifted == '0);
`else
    last    = (cnt_q == CNT_LAST);
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        // End-around carry folds 16 back to 1, so the sum stays congruent mod 15.
        acc_d   = sum[3:0] + {3'b000, sum[4]};
        shreg_d = shifted;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // in_ready is masked by rst so it reads 0 for the whole reset interval.
  assign in_ready      = rst & (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign out_residue   = out_valid ? acc_q : 4'd0;
  assign out_divisible = out_valid & (acc_q[3] ~^ acc_q[1]) & (acc_q[2] ~^ acc_q[0]);

endmodule

// File: doc/div5_serial_ctrl.md
Name: div5_serial_ctrl

Overview:
Sequencing controller for the nibble-serial divisible-by-five datapath. Accepts a BIT_WIDTH-bit operand over a valid/ready handshake and serializes it into 4-bit nibbles, LSB first. Accumulates the nibbles one per cycle in a 4-bit end-around-carry (mod-15) adder, then presents the 4-bit residue and the divisible-by-5 flag over a second valid/ready handshake. Sits between the operand source and any consumer of the divisibility result.

Parameters:
BIT_WIDTH, 32, operand width; must be a multiple of 4 and >= 4 (elaboration error otherwise)
NIBBLES, BIT_WIDTH/4, derived localparam; number of accumulate cycles

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  operand valid
in_ready  output  1  controller can accept an operand
in_data  input  BIT_WIDTH  operand, sampled only on the in_valid & in_ready edge
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_residue  output  4  final end-around-carry accumulator value
out_divisible  output  1  operand divisible by 5
busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; shift register, accumulator and nibble counter cleared; in_ready=0 while reset is held; out_valid=0; out_residue=0; out_divisible=0; busy=0. Any in-flight operation is discarded.
- FSM states: IDLE, ACCUM, DONE.
- IDLE: in_ready=1. On in_valid=1, capture in_data into the shift register, clear the accumulator to 0, clear the counter to 0, go to ACCUM. Otherwise remain in IDLE.
- ACCUM: in_ready=0. Each cycle: s[4:0] = acc + shreg[3:0]; acc <= s[3:0] + s[4]. The second add never overflows, since the maximum is 15+15=30 giving 14+1=15. Then shreg >>= 4 and cnt++. When cnt == NIBBLES-1, go to DONE.
- Changes on in_data after acceptance are ignored.
- DONE: out_valid=1. out_residue=acc. out_divisible = (acc[3] ~^ acc[1]) & (acc[2] ~^ acc[0]), i.e. acc is one of {0,5,10,15}. Both stay stable while out_valid & !out_ready. On out_ready=1, go to IDLE; out_valid drops next cycle.
- Latency: operand accepted at edge T; out_valid is first high after edge T+NIBBLES. Throughput is one operand per NIBBLES+2 cycles minimum.
- Residue semantics: 15 and 0 both mean 0 mod 15. The accumulator returns 15, never 0, once any nonzero nibble has been added.
- in_valid in ACCUM/DONE is ignored (in_ready=0). out_ready outside DONE is ignored.
- Reset asserted in any state aborts immediately. Deassertion resumes in IDLE.

Optional Feature:
Macro: DIV5_EARLY_EXIT_EN
- Defined: in ACCUM, if the shift-register contents after the shift are all zero, go to DONE on that edge regardless of cnt. The capture step is unchanged, so at least one ACCUM cycle always occurs. Latency becomes 1 + index of the highest nonzero nibble, with a minimum of 1.
- Undefined: ACCUM always lasts exactly NIBBLES cycles. Result values are identical either way; only latency differs.

Test Plan:
- in_data=0x00000000, out_ready=1 -> out_valid after 8 cycles, out_residue=0, out_divisible=1; with DIV5_EARLY_EXIT_EN, out_valid after 1 cycle.
- in_data=0xFFFFFFFF -> out_residue=15, out_divisible=1. in_data=0x00000007 -> residue=7, divisible=0.
- in_data=0x12345678 -> out_residue=6, out_divisible=0. in_data=0x0000000A -> residue=10, divisible=1; with DIV5_EARLY_EXIT_EN, latency=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_residue and out_divisible stay constant and in_ready=0. Toggle in_data and in_valid meanwhile -> no effect on the result.
- Reset mid-operation: drive rst=0 asynchronously 3 cycles after accepting 0x12345678 -> outputs go to 0 without a clock edge. After release, in_ready=1 next cycle. Send 0x00000005 -> residue=5, divisible=1.
- Back-to-back: in_valid held high with 100 random operands and random out_ready -> each result matches (operand % 5 == 0), in order, with none dropped or duplicated.
